// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: decoded instruction, register pair,
// FSM state encoding and the trap cause codes this stage can raise.
package mem_stage_pkg;

   typedef struct packed {
      logic lb;
      logic lh;
      logic lw;
      logic lbu;
      logic lhu;
      logic sb;
      logic sh;
      logic sw;
   } mem_op_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic        addi;
      logic        add;
      mem_op_t     mem;
   } instructions;

   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
   } regvpair;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

   function automatic logic is_mem_op(input mem_op_t op);
      return |op;
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads,
// plus misalignment detection. Purely combinational.
module mem_align
   import mem_stage_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        is_load,
   output logic        is_store,
   output logic        misaligned,
   output logic [3:0]  cause,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   always_comb begin
      is_load    = op.lb | op.lh | op.lw | op.lbu | op.lhu;
      is_store   = op.sb | op.sh | op.sw;
      misaligned = ((op.lh | op.lhu | op.sh) & addr_lo[0]) |
                   ((op.lw | op.sw) & (addr_lo != 2'b00));
      cause      = is_load ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;

      wstrb = 4'b0000;
      wdata = 32'h0;
      if (op.sb) begin
         wstrb = 4'b0001 << addr_lo;
         wdata = {4{rs2[7:0]}};
      end else if (op.sh) begin
         wstrb = 4'b0011 << addr_lo;
         wdata = {2{rs2[15:0]}};
      end else if (op.sw) begin
         wstrb = 4'b1111;
         wdata = rs2;
      end

      shifted   = rdata >> {addr_lo, 3'b000};
      load_data = 32'h0;
      if (op.lb)       load_data = {{24{shifted[7]}}, shifted[7:0]};
      else if (op.lbu) load_data = {24'h0, shifted[7:0]};
      else if (op.lh)  load_data = {{16{shifted[15]}}, shifted[15:0]};
      else if (op.lhu) load_data = {16'h0, shifted[15:0]};
      else if (op.lw)  load_data = rdata;
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one request/response transaction per load/store,
// pass-through of the ALU result otherwise, registered completion pulse.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        enabled,
   input  instructions instr,
   input  regvpair     register,
   input  logic [31:0] alu_result,
   output logic        completed,
   output logic [31:0] result,
   output logic        exception,
   output logic [3:0]  cause,
   output logic [31:0] tval,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata
);

   mem_state_t  state;
   mem_op_t     op_q;
   logic [1:0]  addr_lo_q;

   mem_op_t     op_cur;
   logic [1:0]  lo_cur;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic        al_is_load;
   logic        al_is_store;
   logic        al_misaligned;
   logic [3:0]  al_cause;
   logic [31:0] al_load_data;

   logic unused_fields;
   assign unused_fields = ^{instr.pc, instr.imm, instr.addi, instr.add, register.rs1};

   // In IDLE the aligner sees the incoming op; afterwards it sees the latched one.
   assign op_cur = (state == IDLE) ? instr.mem : op_q;
   assign lo_cur = (state == IDLE) ? alu_result[1:0] : addr_lo_q;

   mem_align u_align (
      .op         (op_cur),
      .addr_lo    (lo_cur),
      .rs2        (register.rs2),
      .rdata      (mem_rdata),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .is_load    (al_is_load),
      .is_store   (al_is_store),
      .misaligned (al_misaligned),
      .cause      (al_cause),
      .load_data  (al_load_data)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         op_q          <= '0;
         addr_lo_q     <= 2'b00;
         completed     <= 1'b0;
         result        <= 32'h0;
         exception     <= 1'b0;
         cause         <= 4'h0;
         tval          <= 32'h0;
         mem_req_valid <= 1'b0;
         mem_addr      <= 32'h0;
         mem_we        <= 1'b0;
         mem_wstrb     <= 4'h0;
         mem_wdata     <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               completed <= 1'b0;
               if (enabled) begin
                  if (!is_mem_op(instr.mem)) begin
                     result    <= alu_result;
                     exception <= 1'b0;
                     cause     <= 4'h0;
                     tval      <= 32'h0;
                     completed <= 1'b1;
                     state     <= DONE;
                  end else if (al_misaligned) begin
                     result    <= 32'h0;
                     exception <= 1'b1;
                     cause     <= al_cause;
                     tval      <= alu_result;
                     completed <= 1'b1;
                     state     <= DONE;
                  end else begin
                     op_q          <= instr.mem;
                     addr_lo_q     <= alu_result[1:0];
                     mem_req_valid <= 1'b1;
                     mem_addr      <= {alu_result[31:2], 2'b00};
                     mem_we        <= al_is_store;
                     mem_wstrb     <= al_wstrb;
                     mem_wdata     <= al_wdata;
                     state         <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  result    <= al_is_load ? al_load_data : 32'h0;
                  exception <= 1'b0;
                  cause     <= 4'h0;
                  tval      <= 32'h0;
                  completed <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               completed <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
